// File: rtl/sram_arbiter_pkg.sv
// Shared types and default constants for the SRAM arbiter: FSM encoding,
// SRAM geometry and default access timing.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W      = 19;
  localparam int SRAM_DATA_W      = 16;
  localparam int DEF_WFIFO_DEPTH  = 8;
  localparam int DEF_RD_CYCLES    = 2;
  localparam int DEF_WR_CYCLES    = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_TURN
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle. The arbiter uses the slave
// modport; requesters and the pad/SRAM side use master.
interface sram_arbiter_if #(
  parameter int ADDR_W      = sram_arb_pkg::SRAM_ADDR_W,
  parameter int DATA_W      = sram_arb_pkg::SRAM_DATA_W,
  parameter int WFIFO_DEPTH = sram_arb_pkg::DEF_WFIFO_DEPTH
);
  import sram_arb_pkg::*;

  localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_drop;
  logic [LVL_W-1:0]  wfifo_level;

  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_dq_i,
    output rd_ack, rd_valid, rd_data, wr_ready, wr_drop, wfifo_level,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    output sram_addr, sram_dq_o, sram_dq_oe
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_dq_i,
    input  rd_ack, rd_valid, rd_data, wr_ready, wr_drop, wfifo_level,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    input  sram_addr, sram_dq_o, sram_dq_oe
  );

endinterface

// File: rtl/sram_arbiter_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only the
// pointers and count are.
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for one async SRAM: prioritised VGA reads, FIFO-buffered
// UART writes with a starvation cap, registered strobes and a turnaround cycle.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int WFIFO_DEPTH  = DEF_WFIFO_DEPTH,
  parameter int RD_CYCLES    = DEF_RD_CYCLES,
  parameter int WR_CYCLES    = DEF_WR_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int LVL_W   = $clog2(WFIFO_DEPTH) + 1;
  localparam int ENT_W   = ADDR_W + DATA_W;
  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              grant_rd;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              rd_last;
  logic              wr_last;
  logic              write_due;

  logic              ce_n, oe_n, we_n, dq_oe, rd_valid, wr_drop;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dq_o;
  logic [DATA_W-1:0] rd_data;

  assign push      = bus.wr_valid && !fifo_full;
  assign rd_last   = (state == ST_READ)  && (cnt == CNT_W'(RD_CYCLES - 1));
  assign wr_last   = (state == ST_WRITE) && (cnt == CNT_W'(WR_CYCLES - 1));
  assign write_due = !fifo_empty && (starve_cnt == STV_W'(STARVE_LIMIT));

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.wr_addr, bus.wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    next_state = state;
    grant_rd   = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rd_req && !write_due) begin
          grant_rd   = 1'b1;
          next_state = ST_READ;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_WRITE;
        end
      end
      ST_READ:  if (rd_last) next_state = ST_IDLE;
      ST_WRITE: if (wr_last) next_state = ST_TURN;
      ST_TURN:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // state register: phase counter restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state == state && (state == ST_READ || state == ST_WRITE))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      if (grant_rd && !fifo_empty)
        starve_cnt <= starve_cnt + STV_W'(1);
      else if (pop)
        starve_cnt <= '0;
    end
  end

  // strobes are decoded from next_state so they register glitch-free with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_n     <= 1'b1;
      oe_n     <= 1'b1;
      we_n     <= 1'b1;
      dq_oe    <= 1'b0;
      addr     <= '0;
      dq_o     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_drop  <= 1'b0;
    end else begin
      ce_n  <= !(next_state == ST_READ || next_state == ST_WRITE);
      oe_n  <= (next_state != ST_READ);
      we_n  <= (next_state != ST_WRITE);
      dq_oe <= (next_state == ST_WRITE);
      if (grant_rd) begin
        addr <= bus.rd_addr;
      end else if (pop) begin
        addr <= fifo_dout[ENT_W-1:DATA_W];
        dq_o <= fifo_dout[DATA_W-1:0];
      end
      rd_valid <= rd_last;
      if (rd_last) rd_data <= bus.sram_dq_i;
      if (bus.wr_valid && fifo_full) wr_drop <= 1'b1;
    end
  end

  assign bus.rd_ack      = grant_rd;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data     = rd_data;
  assign bus.wr_ready    = !fifo_full;
  assign bus.wr_drop     = wr_drop;
  assign bus.wfifo_level = fifo_level;
  assign bus.sram_ce_n   = ce_n;
  assign bus.sram_oe_n   = oe_n;
  assign bus.sram_we_n   = we_n;
  assign bus.sram_lb_n   = ce_n;
  assign bus.sram_ub_n   = ce_n;
  assign bus.sram_addr   = addr;
  assign bus.sram_dq_o   = dq_o;
  assign bus.sram_dq_oe  = dq_oe;

endmodule
